// File: rtl/nes_ppu_pkg.sv
// nes_ppu_pkg: shared types and CHR address helpers for the PPU pattern fetch path.
package nes_ppu_pkg;
    typedef enum logic [1:0] {IDLE, FETCH_LO, FETCH_HI} fetch_state_t;
    localparam logic [3:0] CHR_PLANE_OFS = 4'h8;
    localparam int CHR_SIZE = 'h2000;
    localparam int PT_HALF_BIT = 12;
    // Lo-plane address of a tile row; the hi plane is this plus CHR_PLANE_OFS.
    function automatic logic [15:0] chr_addr(input logic pt, input logic [7:0] tile, input logic [2:0] fy);
        return ((16'(pt) << PT_HALF_BIT) | {4'b0000, tile, 1'b0, fy}) & 16'(CHR_SIZE - 1);
    endfunction
endpackage

// File: rtl/chr_pixel_shifter.sv
// chr_pixel_shifter: hold buffer plus 2-plane pixel shifter with gapless reload and sticky underrun.
module chr_pixel_shifter (
    input  logic       ppu_clk,
    input  logic       rst_n,
    input  logic       cap,
    input  logic [7:0] cap_lo,
    input  logic [7:0] cap_hi,
    input  logic       pix_en,
    output logic [1:0] pixel,
    output logic       pix_valid,
    output logic       hold_valid,
    output logic       underrun
);
    logic [7:0] hold_lo, hold_hi, sh_lo, sh_hi;
    logic [3:0] cnt;
    logic reload;
    // Reloading as the last pixel leaves keeps rows back-to-back with no empty cycle.
    assign reload = hold_valid && (cnt == 4'd0 || (cnt == 4'd1 && pix_en));
    assign pix_valid = cnt != 4'd0;
    assign pixel = pix_valid ? {sh_hi[7], sh_lo[7]} : 2'b00;
    always_ff @(posedge ppu_clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_lo <= '0;
            hold_hi <= '0;
            hold_valid <= 1'b0;
            sh_lo <= '0;
            sh_hi <= '0;
            cnt <= '0;
            underrun <= 1'b0;
        end else begin
            if (cap) begin
                hold_lo <= cap_lo;
                hold_hi <= cap_hi;
                hold_valid <= 1'b1;
            end else if (reload) begin
                hold_valid <= 1'b0;
            end
            if (reload) begin
                sh_lo <= hold_lo;
                sh_hi <= hold_hi;
                cnt <= 4'd8;
            end else if (pix_en && pix_valid) begin
                sh_lo <= sh_lo << 1;
                sh_hi <= sh_hi << 1;
                cnt <= cnt - 4'd1;
            end
            if (pix_en && !pix_valid && !hold_valid)
                underrun <= 1'b1;
        end
    end
endmodule

// File: rtl/chr_tile_fetcher.sv
// chr_tile_fetcher: fetches both bitplanes of one CHR tile row from rom_master and
// hands them to the pixel shifter, overlapping the next fetch with shifting.
module chr_tile_fetcher
    import nes_ppu_pkg::*;
#(
    parameter int ROM_LAT = 1
) (
    input  logic        ppu_clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  tile_idx,
    input  logic [2:0]  fine_y,
    input  logic        pt_sel,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] ppu_ab,
    input  logic [7:0]  ppu_do,
    input  logic        pix_en,
    output logic [1:0]  pixel,
    output logic        pix_valid,
    output logic        underrun
);
    localparam int LW = $clog2(ROM_LAT + 1) + 1;
    localparam logic [LW-1:0] LAT_MAX = LW'(ROM_LAT);
    fetch_state_t state;
    logic [LW-1:0] lat;
    logic [7:0] lo_q;
    logic hold_valid, last, cap;
    assign last = lat == LAT_MAX;
    assign cap = state == FETCH_HI && last;
    assign ready = !busy && !hold_valid;
    // The latched request lives in ppu_ab itself; the hi plane only sets the plane bit.
    always_ff @(posedge ppu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            lat <= '0;
            lo_q <= '0;
            ppu_ab <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            lat <= (state == IDLE || last) ? '0 : lat + 1'b1;
            case (state)
                IDLE: if (start && ready) begin
                    ppu_ab <= chr_addr(pt_sel, tile_idx, fine_y);
                    busy <= 1'b1;
                    state <= FETCH_LO;
                end
                FETCH_LO: if (last) begin
                    lo_q <= ppu_do;
                    ppu_ab <= ppu_ab | 16'(CHR_PLANE_OFS);
                    state <= FETCH_HI;
                end
                FETCH_HI: if (last) begin
                    ppu_ab <= '0;
                    busy <= 1'b0;
                    done <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    chr_pixel_shifter u_shifter (
        .ppu_clk(ppu_clk),
        .rst_n(rst_n),
        .cap(cap),
        .cap_lo(lo_q),
        .cap_hi(ppu_do),
        .pix_en(pix_en),
        .pixel(pixel),
        .pix_valid(pix_valid),
        .hold_valid(hold_valid),
        .underrun(underrun)
    );
endmodule

// File: tb/tb_chr_tile_fetcher.sv
// tb_chr_tile_fetcher: scoreboard bench with a behavioural CHR ROM and tile-row pixel model.
module tb_chr_tile_fetcher;
    logic ppu_clk = 1'b0, rst_n = 1'b0, start = 1'b0, pt_sel = 1'b0, pix_en = 1'b0;
    logic [7:0] tile_idx = '0, ppu_do;
    logic [2:0] fine_y = '0;
    logic ready, busy, done, pix_valid, underrun;
    logic [15:0] ppu_ab;
    logic [1:0] pixel;
    int checks = 0, errors = 0, accepted = 0, done_cnt = 0;
    bit allow_ur = 1'b0;
    logic [15:0] exp_ab[$];
    logic [1:0] exp_px[$];
    logic [15:0] prev_ab = '0;

    chr_tile_fetcher #(.ROM_LAT(1)) dut (
        .ppu_clk(ppu_clk), .rst_n(rst_n), .start(start), .tile_idx(tile_idx),
        .fine_y(fine_y), .pt_sel(pt_sel), .ready(ready), .busy(busy), .done(done),
        .ppu_ab(ppu_ab), .ppu_do(ppu_do), .pix_en(pix_en), .pixel(pixel),
        .pix_valid(pix_valid), .underrun(underrun)
    );

    always #5 ppu_clk = ~ppu_clk;

    function automatic logic [7:0] chr(input logic [15:0] a);
        if (a == 16'h0013) return 8'hA5;
        if (a == 16'h001B) return 8'h3C;
        return 8'(a[7:0] * 8'd29) ^ {3'b000, a[12:8]} ^ 8'h6C;
    endfunction

    // Registered CHR ROM with one cycle of latency.
    always @(posedge ppu_clk) ppu_do <= chr(ppu_ab);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] t, input logic [2:0] fy, input bit pt);
        logic [15:0] lo;
        logic [7:0] d_lo, d_hi;
        lo = 16'(pt) * 16'h1000 + 16'(t) * 16'd16 + 16'(fy);
        d_lo = chr(lo);
        d_hi = chr(lo + 16'd8);
        exp_ab.push_back(lo);
        exp_ab.push_back(lo + 16'd8);
        for (int i = 7; i >= 0; i--) exp_px.push_back({d_hi[i], d_lo[i]});
        accepted++;
    endtask

    task automatic step(input bit s, input logic [7:0] t, input logic [2:0] fy, input bit pt, input bit pe);
        start = s;
        tile_idx = t;
        fine_y = fy;
        pt_sel = pt;
        pix_en = pe;
        if (s && ready && rst_n) push(t, fy, pt);
        @(posedge ppu_clk);
        #1;
        start = 1'b0;
        pix_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (exp_px.size() != 0 || busy); i++)
            step(1'b0, 8'h00, 3'd0, 1'b0, pix_valid);
        chk("drain_left", 32'(exp_px.size()), 32'd0);
    endtask

    always @(negedge ppu_clk) begin
        logic [15:0] ea;
        logic [1:0] ep;
        if (!rst_n) begin
            prev_ab = '0;
        end else begin
            chk("ab_range", 32'(ppu_ab <= 16'h1FFF), 32'd1);
            if (ppu_ab !== prev_ab && ppu_ab != 16'h0000) begin
                if (exp_ab.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ppu_ab_unexpected actual=%0h required=none at %0t", ppu_ab, $time);
                end else begin
                    ea = exp_ab.pop_front();
                    chk("ppu_ab", 32'(ppu_ab), 32'(ea));
                end
            end
            prev_ab = ppu_ab;
            if (done) done_cnt++;
            if (pix_en) begin
                if (allow_ur) begin
                    chk("ur_pix_valid", 32'(pix_valid), 32'd0);
                    chk("ur_pixel", 32'(pixel), 32'd0);
                end else begin
                    chk("pix_valid_on_en", 32'(pix_valid), 32'd1);
                    if (exp_px.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pixel_unexpected actual=%0d required=none at %0t", pixel, $time);
                    end else begin
                        ep = exp_px.pop_front();
                        chk("pixel", 32'(pixel), 32'(ep));
                    end
                end
            end
        end
    end

    initial begin
        #1;
        chk("rst_ab", 32'(ppu_ab), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pixel", 32'(pixel), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        repeat (2) @(posedge ppu_clk);
        #1 rst_n = 1'b1;
        idle(2);
        // Reset in the middle of the hi-plane fetch.
        step(1'b1, 8'h42, 3'd5, 1'b0, 1'b0);
        idle(3);
        chk("mid_state_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ab", 32'(ppu_ab), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        exp_ab.delete();
        exp_px.delete();
        accepted = 0;
        done_cnt = 0;
        @(posedge ppu_clk);
        #1 rst_n = 1'b1;
        idle(6);
        chk("no_done_after_rst", 32'(done_cnt), 32'd0);
        chk("no_pix_after_rst", 32'(pix_valid), 32'd0);
        // Reference row: tile 1, fine_y 3, lo $A5 / hi $3C.
        step(1'b1, 8'h01, 3'd3, 1'b0, 1'b0);
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_ready", 32'(ready), 32'd0);
        chk("t2_ab_lo", 32'(ppu_ab), 32'h0013);
        idle(2);
        chk("t2_ab_hi", 32'(ppu_ab), 32'h001B);
        idle(1);
        chk("t2_done_e3", 32'(done), 32'd0);
        idle(1);
        chk("t2_done_e4", 32'(done), 32'd1);
        chk("t2_busy_e4", 32'(busy), 32'd0);
        idle(1);
        chk("t2_done_e5", 32'(done), 32'd0);
        chk("t2_pix_valid", 32'(pix_valid), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        chk("t2_pix_valid_end", 32'(pix_valid), 32'd0);
        chk("t2_underrun", 32'(underrun), 32'd0);
        chk("t2_done_cnt", 32'(done_cnt), 32'(accepted));
        // Top of the CHR space.
        step(1'b1, 8'hFF, 3'd7, 1'b1, 1'b0);
        idle(6);
        drain();
        // Start ignored while busy and while the hold buffer is occupied.
        step(1'b1, 8'h10, 3'd2, 1'b0, 1'b0);
        idle(5);
        chk("t4_shifter_full", 32'(pix_valid), 32'd1);
        step(1'b1, 8'h20, 3'd6, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("t4_ready_busy", 32'(ready), 32'd0);
            step(1'b1, 8'h77, 3'd1, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            chk("t4_ready_hold", 32'(ready), 32'd0);
            chk("t4_busy_hold", 32'(busy), 32'd0);
            step(1'b1, 8'h55, 3'd4, 1'b0, 1'b0);
        end
        chk("t4_done_cnt", 32'(done_cnt), 32'(accepted));
        drain();
        // Back-to-back rows with pix_en held high.
        step(1'b1, 8'h33, 3'd4, 1'b0, 1'b0);
        idle(5);
        for (int i = 0; i < 16; i++) step(i == 0, 8'h34, 3'd5, 1'b1, 1'b1);
        chk("t5_pix_valid_end", 32'(pix_valid), 32'd0);
        chk("t5_underrun", 32'(underrun), 32'd0);
        chk("t5_done_cnt", 32'(done_cnt), 32'(accepted));
        // Randomised traffic.
        for (int i = 0; i < 400; i++)
            step(($urandom % 3) == 0, 8'($urandom_range(1, 255)), 3'($urandom % 8), 1'($urandom % 2),
                 pix_valid && (($urandom % 4) != 0));
        drain();
        chk("rnd_underrun", 32'(underrun), 32'd0);
        chk("rnd_done_cnt", 32'(done_cnt), 32'(accepted));
        chk("rnd_ab_left", 32'(exp_ab.size()), 32'd0);
        // Underrun on the ninth pixel, sticky until reset.
        step(1'b1, 8'h5A, 3'd0, 1'b1, 1'b0);
        idle(5);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        chk("t6_no_underrun_yet", 32'(underrun), 32'd0);
        allow_ur = 1'b1;
        step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        allow_ur = 1'b0;
        chk("t6_underrun", 32'(underrun), 32'd1);
        idle(3);
        chk("t6_underrun_sticky", 32'(underrun), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_underrun_rst", 32'(underrun), 32'd0);
        @(posedge ppu_clk);
        #1 rst_n = 1'b1;
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
